// File: rtl/rram_wv_ctrl.sv
// Initiator-side controller for the single-port RRAM macro.
// It sequences host reads and verified writes, and retries a write a bounded number of times.
module rram_wv_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int MAX_RETRIES = 3,
    parameter int RETRY_W     = 3
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [RETRY_W-1:0]    resp_retries,
    output logic                  mem_csb0,
    output logic                  mem_web0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_VRD,
        S_VWAIT,
        S_RD,
        S_RWAIT,
        S_RESP
    } state_t;

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_t               state;
    state_t               state_nxt;
    logic [RETRY_W-1:0]   retry_q;
    logic                 accept;
    logic                 verify_ok;
    logic                 can_retry;
    logic                 macro_active_nxt;

    assign accept    = (state == S_IDLE) && req_valid && req_ready;
    // mem_din0 holds the latched write data for the whole write/verify loop.
    assign verify_ok = (mem_dout0 == mem_din0);
    assign can_retry = (retry_q < RETRY_MAX);

    assign macro_active_nxt = (state_nxt == S_WR) || (state_nxt == S_VRD) ||
                              (state_nxt == S_RD);

    // NOTE: asynchronous reset puts every flop, including mem_csb0, in its idle value
    // at once, so an aborted access never reaches a capturing edge.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = req_we ? S_WR : S_RD;
                end
            end
            S_WR:    state_nxt = S_VRD;
            S_VRD:   state_nxt = S_VWAIT;
            S_VWAIT: begin
                if (verify_ok || !can_retry) begin
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_WR;
                end
            end
            S_RD:    state_nxt = S_RWAIT;
            S_RWAIT: state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state cycle.
    // NOTE: all state and output flops use non-blocking assignments so every flop
    // samples pre-edge values.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            resp_retries <= '0;
            retry_q      <= '0;
            mem_csb0     <= 1'b1;
            mem_web0     <= 1'b1;
            mem_addr0    <= '0;
            mem_din0     <= '0;
        end else begin
            req_ready  <= (state_nxt == S_IDLE);
            resp_valid <= (state_nxt == S_RESP);
            mem_csb0   <= !macro_active_nxt;
            mem_web0   <= (state_nxt != S_WR);

            if (accept) begin
                mem_addr0 <= req_addr;
                retry_q   <= '0;
                if (req_we) begin
                    mem_din0 <= req_wdata;
                end
            end else if ((state == S_VWAIT) && !verify_ok && can_retry) begin
                retry_q <= retry_q + RETRY_W'(1);
            end

            if ((state == S_VWAIT) || (state == S_RWAIT)) begin
                resp_rdata <= mem_dout0;
            end

            // Response status is fixed once, on the edge that enters RESP.
            if (state == S_VWAIT && state_nxt == S_RESP) begin
                resp_err     <= !verify_ok;
                resp_retries <= retry_q;
            end else if (state == S_RWAIT) begin
                resp_err     <= 1'b0;
                resp_retries <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rram_wv_ctrl.sv
// Self-checking bench for rram_wv_ctrl with a behavioural RRAM macro and a
// transaction-level model of the expected responses.
module tb_rram_wv_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int MAXR = 3;
    localparam int RW   = 3;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [RW-1:0] resp_retries;
    logic          mem_csb0;
    logic          mem_web0;
    logic [AW-1:0] mem_addr0;
    logic [DW-1:0] mem_din0;
    logic [DW-1:0] mem_dout0 = '0;

    always #5 clk0 = ~clk0;

    rram_wv_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_RETRIES(MAXR),
        .RETRY_W    (RW)
    ) dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .resp_retries(resp_retries),
        .mem_csb0    (mem_csb0),
        .mem_web0    (mem_web0),
        .mem_addr0   (mem_addr0),
        .mem_din0    (mem_din0),
        .mem_dout0   (mem_dout0)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fault injection: 0 none, 1 flip bit 0 on write number flip_at, 2 bit 15 stuck at 0.
    int fault_mode = 0;
    int flip_at    = -1;
    int csb_cnt    = 0;
    int wr_cnt     = 0;
    logic [DW-1:0] mem [16];

    function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] d, input bit first);
        if (fault_mode == 2) return d & 16'h7FFF;
        if (fault_mode == 1 && first) return d ^ 16'h0001;
        return d;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[5] = 16'hBEEF;
    end

    always @(posedge clk0) begin
        if (!mem_csb0) begin
            csb_cnt <= csb_cnt + 1;
            if (!mem_web0) begin
                wr_cnt <= wr_cnt + 1;
                mem[mem_addr0] <= corrupt(mem_din0, wr_cnt == flip_at);
            end else begin
                mem_dout0 <= mem[mem_addr0];
            end
        end
    end

    // Transaction-level model: what the host must see for one request.
    logic [DW-1:0] model_mem [16];
    bit            exp_armed   = 1'b0;
    logic [DW-1:0] exp_rdata   = '0;
    bit            exp_err     = 1'b0;
    int            exp_retries = 0;
    int            exp_lat     = 0;
    int            exp_wr      = 0;
    int            exp_csb     = 0;

    task automatic model_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] stored;
        int  att;
        bit  done;
        if (!we) begin
            exp_rdata = model_mem[a]; exp_err = 1'b0; exp_retries = 0;
            exp_lat = 3; exp_wr = 0; exp_csb = 1;
        end else begin
            att = 0; done = 1'b0; stored = '0;
            while (!done) begin
                stored = corrupt(d, att == 0);
                model_mem[a] = stored;
                if (stored == d) begin
                    exp_err = 1'b0; done = 1'b1;
                end else if (att == MAXR) begin
                    exp_err = 1'b1; done = 1'b1;
                end else begin
                    att++;
                end
            end
            exp_rdata = stored; exp_retries = att;
            exp_lat = 4 + 3 * att; exp_wr = att + 1; exp_csb = 2 * (att + 1);
        end
    endtask

    // Every cycle a response is presented it must match the model and stay stable.
    always @(negedge clk0) begin
        if (!rst0 && resp_valid) begin
            check("resp_expected", 32'(exp_armed), 32'd1);
            check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
            check("resp_err", 32'(resp_err), 32'(exp_err));
            check("resp_retries", 32'(resp_retries), 32'(exp_retries));
            check("req_ready_in_resp", 32'(req_ready), 32'd0);
        end
    end

    task automatic run_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int hold, input int h_lat, input logic [DW-1:0] h_rdata,
                           input int h_retries, input bit h_err, input int h_wr);
        int idx;
        int c0;
        int w0;
        model_txn(we, a, d);
        exp_armed = 1'b1;
        @(negedge clk0);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        c0 = csb_cnt; w0 = wr_cnt;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk0);
        req_valid = 1'b0;
        idx = 1;
        while (!resp_valid && idx < 200) begin
            @(negedge clk0);
            idx++;
        end
        check("latency_model", 32'(idx), 32'(exp_lat));
        check("latency_hand", 32'(idx), 32'(h_lat));
        check("rdata_hand", 32'(resp_rdata), 32'(h_rdata));
        check("retries_hand", 32'(resp_retries), 32'(h_retries));
        check("err_hand", 32'(resp_err), 32'(h_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk0);
            check("hold_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk0);
        resp_ready = 1'b0;
        check("valid_drop", 32'(resp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
        check("csb_low_cycles", 32'(csb_cnt - c0), 32'(exp_csb));
        check("wr_pulses_model", 32'(wr_cnt - w0), 32'(exp_wr));
        check("wr_pulses_hand", 32'(wr_cnt - w0), 32'(h_wr));
        exp_armed = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_rv;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_mem[5] = 16'hBEEF;

        // Reset values, held in reset and after 5 idle cycles.
        #12;
        check("rst_csb", 32'(mem_csb0), 32'd1);
        check("rst_web", 32'(mem_web0), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk0);
        rst0 = 1'b0;
        repeat (5) @(negedge clk0);
        check("idle_csb", 32'(mem_csb0), 32'd1);
        check("idle_web", 32'(mem_web0), 32'd1);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("idle_rdata", 32'(resp_rdata), 32'd0);
        check("idle_err", 32'(resp_err), 32'd0);
        check("idle_retries", 32'(resp_retries), 32'd0);
        check("idle_addr", 32'(mem_addr0), 32'd0);
        check("idle_din", 32'(mem_din0), 32'd0);

        //      we    addr   data      hold lat rdata     ret err wr
        run_txn(1'b0, 4'h5, 16'h0000, 0,   3,  16'hBEEF, 0,  0,  0);
        run_txn(1'b1, 4'hC, 16'hA5A5, 0,   4,  16'hA5A5, 0,  0,  1);

        fault_mode = 1; flip_at = wr_cnt;
        run_txn(1'b1, 4'h7, 16'h1234, 0,   7,  16'h1234, 1,  0,  2);
        fault_mode = 2;
        run_txn(1'b1, 4'h3, 16'h8000, 0,   13, 16'h0000, 3,  1,  4);
        fault_mode = 0;

        run_txn(1'b0, 4'hC, 16'h0000, 6,   3,  16'hA5A5, 0,  0,  0);
        run_txn(1'b0, 4'h7, 16'h0000, 0,   3,  16'h1234, 0,  0,  0);

        // Abort a write with reset during its verify read.
        exp_armed = 1'b0;
        @(negedge clk0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h9; req_wdata = 16'h0F0F;
        @(negedge clk0);
        req_valid = 1'b0;
        @(posedge clk0);
        #2;
        check("vrd_csb_low", 32'(mem_csb0), 32'd0);
        rst0 = 1'b1;
        #1;
        check("abort_csb", 32'(mem_csb0), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        model_mem[9] = 16'h0F0F;
        @(negedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
        seen_rv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk0);
            if (resp_valid) seen_rv++;
        end
        check("abort_no_resp", 32'(seen_rv), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);

        run_txn(1'b0, 4'h9, 16'h0000, 0,   3,  16'h0F0F, 0,  0,  0);

        repeat (2) @(negedge clk0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
